// File: rtl/uart_pkg.sv
// Shared definitions for the serial link: FSM state encoding, default link
// parameters and the line idle level. Optional parity build macro: UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // 100 MHz system clock at 9600 baud
  localparam int unsigned DefClksPerBit = 10417;
  localparam int unsigned DefDataBits   = 8;

  localparam logic IdleLevel = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of
// each serial bit. Held at zero while clear_i is high, so the first bit after
// release is a full period. Shared with the future receiver.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero on clear, wrap at the bit boundary
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == MaxCnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = !clear_i && (cnt_q == MaxCnt);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even
// parity bit (build macro UART_TX_PARITY_EN), stop bit. The line is a register
// loaded from the current state, so tx trails the state by one clock.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned DATA_BITS    = DefDataBits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_start_i,
  output logic                 tx_ready_o,
  output logic                 tx_done_o,
  output logic                 tx_o
);

  // One extra bit so the index can reach DATA_BITS without wrapping
  localparam int unsigned IdxW = $clog2(DATA_BITS) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_tick;
  logic                 cnt_clear;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign cnt_clear = (state_q == StIdle);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .bit_tick_o(bit_tick)
  );

  // Next state, shift/index updates and next line level
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = IdleLevel;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_start_i) begin
          state_d   = StStart;
          shift_d   = tx_data_i;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data_i;
`endif
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_tick) state_d = StData;
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = parity_q;
        if (bit_tick) state_d = StStop;
      end
`endif
      StStop: begin
        tx_d = IdleLevel;
        if (bit_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and line registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IdleLevel;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte latched at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx_ready_o = (state_q == StIdle);
  assign tx_done_o  = (state_q == StStop) && bit_tick;
  assign tx_o       = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with CLKS_PER_BIT=4, DATA_BITS=8.
// Expected frame bits are queued when a frame is launched and popped as the
// line is sampled, one entry per serial bit.
module tb_uart_tx_serializer;

  localparam int unsigned C = 4;
  localparam int unsigned D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBits = D + 3;
`else
  localparam int unsigned NBits = D + 2;
`endif

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic [D-1:0] tx_data  = '0;
  logic         tx_start = 1'b0;
  logic         tx_ready;
  logic         tx_done;
  logic         tx;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  uart_tx_serializer #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data_i (tx_data),
    .tx_start_i(tx_start),
    .tx_ready_o(tx_ready),
    .tx_done_o (tx_done),
    .tx_o      (tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line idle: tx=1, ready=1, done=0 for n cycles
  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 8'({tx, tx_ready, tx_done}), 8'b110);
    end
  endtask

  task automatic push_frame(input logic [D-1:0] data);
    exp_q.push_back(1'b0);
    for (int i = 0; i < D; i++) exp_q.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^data);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Launch one frame and check every cycle up to and including edge N+F.
  // hold keeps tx_start high; inj_at>0 pulses tx_start with 0x3C at that cycle.
  task automatic run_frame(input logic [D-1:0] data, input bit hold, input int inj_at,
                           input string tag);
    int  dones;
    int  idx;
    bit  last;
    dones    = 0;
    tx_data  = data;
    tx_start = 1'b1;
    step();  // accept edge N
    chk({tag, "_acc_tx"}, 8'(tx), 8'd1);
    if (!hold) tx_start = 1'b0;
    tx_data = ~data;
    push_frame(data);
    for (int b = 0; b < NBits; b++) begin
      for (int c = 0; c < C; c++) begin
        idx = b * C + c + 1;
        if (inj_at != 0) begin
          tx_start = (idx == inj_at);
          if (idx == inj_at) tx_data = 8'h3C;
        end
        step();
        last = (b == NBits - 1);
        chk({tag, "_tx"}, 8'(tx), 8'(exp_q[0]));
        chk({tag, "_ready"}, 8'(tx_ready), 8'(last && (c == C - 1)));
        chk({tag, "_done"}, 8'(tx_done), 8'(last && (c == C - 2)));
        if (tx_done) dones++;
        if (c == C - 1) void'(exp_q.pop_front());
      end
    end
    tx_start = hold;
    chk({tag, "_ndone"}, 8'(dones), 8'd1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_held", 8'({tx, tx_ready, tx_done}), 8'b110);
    reset = 1'b0;
    idle_chk("rst_idle", 100);

    run_frame(8'hA5, 1'b0, 0, "a5");
    idle_chk("a5_post", 5);

    run_frame(8'hFF, 1'b0, 10, "busy");
    idle_chk("busy_post", 20);

    run_frame(8'h00, 1'b1, 0, "b2b0");
    run_frame(8'hFF, 1'b0, 0, "b2b1");
    idle_chk("b2b_post", 5);

    // Reset during data bit 3 of an all-zero frame
    tx_data  = 8'h00;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (17) step();
    chk("mr_pre_tx", 8'(tx), 8'd0);
    chk("mr_pre_ready", 8'(tx_ready), 8'd0);
    #2 reset = 1'b1;
    #1;
    chk("mr_async", 8'({tx, tx_ready, tx_done}), 8'b110);
    step();
    step();
    reset = 1'b0;
    idle_chk("mr_post", 30);

`ifdef UART_TX_PARITY_EN
    run_frame(8'hA5, 1'b0, 0, "par_a5");
    idle_chk("par_gap", 3);
    run_frame(8'h07, 1'b0, 0, "par_07");
    idle_chk("par_post", 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
